dataflow_invariant_q: RTL and testbench

Queued, re-armable dataflow invariant. Each value accepted on `a` is held at the head of a DEPTH-entry queue and replayed on `o` once per `d` token; a `d` token carrying `d_last` retires the head so the next queued value becomes the invariant. This is the successor to the single-shot invariant in the dataflow library. It serves loop nests where the outer loop supplies a new invariant per inner-loop trip, and it lets the producer prefetch upcoming values while the current one is still in use.

---
 rtl/dataflow_invariant_q.sv | 153 +++++++++++++++
 tb/tb_dataflow_invariant_q.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataflow_invariant_q.sv
// ---------------------------------------------------------------------------
// dataflow_invariant_q
//
// Queued, re-armable dataflow invariant. Values accepted on the a-side are
// stored in a small circular queue. The value at the head is replayed on the
// o-side once for every d token. A d token flagged d_last retires the head,
// and the next queued value becomes the invariant in the following cycle.
// The producer can therefore prefetch upcoming invariants while the current
// one is still being consumed.
//
// Parameters:
//   WIDTH     - data width of a_data / o_data
//   DEPTH     - number of queue entries (power of two, >= 2)
//   CNT_WIDTH - width of the per-value use counter (statistics build only)
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   d_valid    in   replay-request token valid
//   d_ready    out  replay-request token accepted
//   d_last     in   token is the last use of the current head value
//   a_valid    in   new invariant value valid
//   a_ready    out  queue has room for a value
//   a_data     in   invariant value
//   o_valid    out  replayed value valid
//   o_ready    in   downstream accepts the replayed value
//   o_data     out  head value (0 while the queue is empty)
//   o_last     out  d_last of the token being forwarded
//   occupancy  out  number of stored values
//   stat_reps  out  total uses of the most recently retired value
//                   (only when DATAFLOW_INVARIANT_Q_STATS_EN is defined)
//
// Optional feature macro: DATAFLOW_INVARIANT_Q_STATS_EN
// ---------------------------------------------------------------------------
module dataflow_invariant_q #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 2,
   parameter int CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       d_valid,
   output logic                       d_ready,
   input  logic                       d_last,
   input  logic                       a_valid,
   output logic                       a_ready,
   input  logic [WIDTH-1:0]           a_data,
   output logic                       o_valid,
   input  logic                       o_ready,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_last,
   output logic [$clog2(DEPTH):0]     occupancy
`ifdef DATAFLOW_INVARIANT_Q_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]       stat_reps
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd;
   logic [PTR_W-1:0] wr;
   logic [CNT_W-1:0] count;

   logic empty;
   logic full;
   logic a_fire;
   logic d_fire;
   logic pop;

   // Handshake decode. Every ready/valid depends only on registered state and
   // the opposite side's valid/ready, so nothing on the a-side reaches the
   // o-side in the same cycle: a pushed value becomes visible one cycle later.
   // a_ready deliberately ignores a same-cycle pop, so a full queue never
   // accepts a value in the cycle that frees a slot.
   always_comb begin
      empty   = (count == '0);
      full    = (count == FULL_COUNT);
      a_ready = !full;
      a_fire  = a_valid && !full;
      o_valid = d_valid && !empty;
      d_ready = o_ready && !empty;
      d_fire  = d_valid && o_ready && !empty;
      o_last  = d_last && o_valid;
      pop     = d_fire && d_last;
      o_data  = empty ? '0 : mem[rd];
   end

   assign occupancy = count;

   // Queue storage. The entries carry no reset: the pointers and count decide
   // what is live, so stale contents after a reset are never observed.
   always_ff @(posedge clk) begin
      if (a_fire) begin
         mem[wr] <= a_data;
      end
   end

   // Pointer and count bookkeeping. A push and a pop in the same cycle both
   // move their pointers while the count stays put. DEPTH is a power of two,
   // so the pointers wrap simply by overflowing.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (a_fire) begin
            wr <= wr + PTR_W'(1);
         end
         if (pop) begin
            rd <= rd + PTR_W'(1);
         end
         case ({a_fire, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef DATAFLOW_INVARIANT_Q_STATS_EN
   logic [CNT_WIDTH-1:0] use_cnt;
   logic [CNT_WIDTH-1:0] use_cnt_inc;

   // Saturating "one more use" of the current head, shared by the running
   // counter and by the value latched when the head retires.
   always_comb begin
      use_cnt_inc = (use_cnt == '1) ? use_cnt : use_cnt + CNT_WIDTH'(1);
   end

   // Use statistics. Every fire on the head counts; on the retiring fire the
   // total (including that fire) is published on stat_reps and the running
   // counter restarts for the next head. stat_reps holds between retirements.
   always_ff @(posedge clk) begin
      if (rst) begin
         use_cnt   <= '0;
         stat_reps <= '0;
      end else if (d_fire) begin
         if (d_last) begin
            stat_reps <= use_cnt_inc;
            use_cnt   <= '0;
         end else begin
            use_cnt   <= use_cnt_inc;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dataflow_invariant_q.sv
// ---------------------------------------------------------------------------
// tb_dataflow_invariant_q
//
// Directed testbench for dataflow_invariant_q (WIDTH=32, DEPTH=2). Each task
// drives one scenario and compares the DUT outputs against hand-computed
// values. Inputs change 1 time unit after the rising edge; outputs are
// sampled 2 time units later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_dataflow_invariant_q;

   logic        clk = 1'b0;
   logic        rst;
   logic        d_valid;
   logic        d_ready;
   logic        d_last;
   logic        a_valid;
   logic        a_ready;
   logic [31:0] a_data;
   logic        o_valid;
   logic        o_ready;
   logic [31:0] o_data;
   logic        o_last;
   logic [1:0]  occupancy;
`ifdef DATAFLOW_INVARIANT_Q_STATS_EN
   logic [15:0] stat_reps;
`endif

   int vectors = 0;
   int errors  = 0;

   dataflow_invariant_q #(
      .WIDTH(32),
      .DEPTH(2),
      .CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .d_valid(d_valid),
      .d_ready(d_ready),
      .d_last(d_last),
      .a_valid(a_valid),
      .a_ready(a_ready),
      .a_data(a_data),
      .o_valid(o_valid),
      .o_ready(o_ready),
      .o_data(o_data),
      .o_last(o_last),
      .occupancy(occupancy)
`ifdef DATAFLOW_INVARIANT_Q_STATS_EN
      ,
      .stat_reps(stat_reps)
`endif
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1; d_valid = 1'b1; d_last = 1'b0; o_ready = 1'b1;
      a_valid = 1'b0; a_data = '0;
      tick(); tick();
      rst = 1'b0;
      settle();
      vectors++;
      if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_valid got %b want 0", o_valid); end
      vectors++;
      if (d_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_d_ready got %b want 0", d_ready); end
      vectors++;
      if (o_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_last got %b want 0", o_last); end
      vectors++;
      if (o_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_o_data got %h want 0", o_data); end
      vectors++;
      if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occupancy got %0d want 0", occupancy); end
      vectors++;
      if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_a_ready got %b want 1", a_ready); end
`ifdef DATAFLOW_INVARIANT_Q_STATS_EN
      vectors++;
      if (stat_reps !== 16'd0) begin errors++; $display("[TB] FAIL reset_stat_reps got %0d want 0", stat_reps); end
`endif
      d_valid = 1'b0;
   endtask

   task automatic test_single_value();
      a_valid = 1'b1; a_data = 32'hA5;
      tick();
      a_valid = 1'b0;
      d_valid = 1'b1; o_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d_last = (i == 3);
         settle();
         vectors++;
         if (o_data !== 32'hA5 || o_valid !== 1'b1 || d_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL single_fire%0d data %h valid %b ready %b want a5 1 1", i, o_data, o_valid, d_ready); end
         vectors++;
         if (o_last !== (i == 3))
            begin errors++; $display("[TB] FAIL single_last%0d got %b want %b", i, o_last, (i == 3)); end
         vectors++;
         if (occupancy !== 2'd1)
            begin errors++; $display("[TB] FAIL single_occ%0d got %0d want 1", i, occupancy); end
         tick();
      end
      d_valid = 1'b0; d_last = 1'b0;
      settle();
      vectors++;
      if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL single_drained got %0d want 0", occupancy); end
   endtask

   task automatic test_empty_stall();
      d_valid = 1'b1; d_last = 1'b1; o_ready = 1'b1;
      a_valid = 1'b1; a_data = 32'h7;
      settle();
      vectors++;
      if (d_ready !== 1'b0 || o_valid !== 1'b0 || o_last !== 1'b0)
         begin errors++; $display("[TB] FAIL empty_stall ready %b valid %b last %b want 0 0 0", d_ready, o_valid, o_last); end
      tick();
      a_valid = 1'b0;
      settle();
      vectors++;
      if (o_valid !== 1'b1 || d_ready !== 1'b1 || o_data !== 32'h7 || o_last !== 1'b1)
         begin errors++; $display("[TB] FAIL empty_first_fire valid %b ready %b data %h last %b want 1 1 7 1", o_valid, d_ready, o_data, o_last); end
      tick();
      d_valid = 1'b0;
      settle();
      vectors++;
      if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL empty_popped got %0d want 0", occupancy); end
   endtask

   task automatic test_full();
      d_valid = 1'b0; d_last = 1'b0; o_ready = 1'b1;
      a_valid = 1'b1; a_data = 32'h11; tick();
      a_data = 32'h22; tick();
      a_data = 32'h33;
      settle();
      vectors++;
      if (a_ready !== 1'b0 || occupancy !== 2'd2)
         begin errors++; $display("[TB] FAIL full_blocked a_ready %b occ %0d want 0 2", a_ready, occupancy); end
      tick();
      d_valid = 1'b1; d_last = 1'b1;
      settle();
      vectors++;
      if (a_ready !== 1'b0 || o_data !== 32'h11 || o_last !== 1'b1)
         begin errors++; $display("[TB] FAIL full_pop_cycle a_ready %b data %h last %b want 0 11 1", a_ready, o_data, o_last); end
      tick();
      d_valid = 1'b0;
      settle();
      vectors++;
      if (a_ready !== 1'b1 || o_data !== 32'h22 || occupancy !== 2'd1)
         begin errors++; $display("[TB] FAIL full_after_pop a_ready %b data %h occ %0d want 1 22 1", a_ready, o_data, occupancy); end
      tick();
      a_valid = 1'b0;
      d_valid = 1'b1;
      settle();
      vectors++;
      if (occupancy !== 2'd2 || o_data !== 32'h22)
         begin errors++; $display("[TB] FAIL full_refilled occ %0d data %h want 2 22", occupancy, o_data); end
      tick();
      settle();
      vectors++;
      if (o_data !== 32'h33 || occupancy !== 2'd1)
         begin errors++; $display("[TB] FAIL full_third data %h occ %0d want 33 1", o_data, occupancy); end
      tick();
      d_valid = 1'b0; d_last = 1'b0;
      settle();
      vectors++;
      if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL full_drained got %0d want 0", occupancy); end
   endtask

   task automatic test_back_to_back();
      a_valid = 1'b1; a_data = 32'h44; tick();
      a_data = 32'h55; d_valid = 1'b1; d_last = 1'b1; o_ready = 1'b1;
      settle();
      vectors++;
      if (o_data !== 32'h44 || occupancy !== 2'd1)
         begin errors++; $display("[TB] FAIL b2b_before data %h occ %0d want 44 1", o_data, occupancy); end
      tick();
      a_valid = 1'b0;
      settle();
      vectors++;
      if (o_data !== 32'h55 || occupancy !== 2'd1)
         begin errors++; $display("[TB] FAIL b2b_after data %h occ %0d want 55 1", o_data, occupancy); end
      tick();
      d_valid = 1'b0; d_last = 1'b0;
      settle();
      vectors++;
      if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL b2b_drained got %0d want 0", occupancy); end
   endtask

   task automatic test_backpressure();
      a_valid = 1'b1; a_data = 32'h66; tick();
      a_valid = 1'b0;
      d_valid = 1'b1; d_last = 1'b1; o_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         vectors++;
         if (d_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 32'h66 || occupancy !== 2'd1)
            begin errors++; $display("[TB] FAIL bp_hold%0d ready %b valid %b data %h occ %0d want 0 1 66 1", i, d_ready, o_valid, o_data, occupancy); end
         tick();
      end
      o_ready = 1'b1;
      tick();
      d_valid = 1'b0; d_last = 1'b0;
      settle();
      vectors++;
      if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL bp_released got %0d want 0", occupancy); end
   endtask

   task automatic test_reset_mid();
      a_valid = 1'b1; a_data = 32'h1; tick();
      a_data = 32'h2; tick();
      a_valid = 1'b0;
      rst = 1'b1; tick();
      rst = 1'b0; d_valid = 1'b1; d_last = 1'b1; o_ready = 1'b1;
      settle();
      vectors++;
      if (occupancy !== 2'd0 || o_valid !== 1'b0)
         begin errors++; $display("[TB] FAIL rstmid_cleared occ %0d valid %b want 0 0", occupancy, o_valid); end
      a_valid = 1'b1; a_data = 32'h5;
      tick();
      a_valid = 1'b0;
      settle();
      vectors++;
      if (o_data !== 32'h5 || o_valid !== 1'b1)
         begin errors++; $display("[TB] FAIL rstmid_fresh data %h valid %b want 5 1", o_data, o_valid); end
      tick();
      d_valid = 1'b0; d_last = 1'b0;
      settle();
      vectors++;
      if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL rstmid_drained got %0d want 0", occupancy); end
   endtask

`ifdef DATAFLOW_INVARIANT_Q_STATS_EN
   task automatic test_stats();
      a_valid = 1'b1; a_data = 32'h11; tick();
      a_valid = 1'b0;
      d_valid = 1'b1; o_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d_last = (i == 3);
         tick();
      end
      d_valid = 1'b0; d_last = 1'b0;
      settle();
      vectors++;
      if (stat_reps !== 16'd4) begin errors++; $display("[TB] FAIL stats_reps got %0d want 4", stat_reps); end
      tick(); tick();
      vectors++;
      if (stat_reps !== 16'd4) begin errors++; $display("[TB] FAIL stats_hold got %0d want 4", stat_reps); end
   endtask
`endif

   initial begin
      rst = 1'b1; d_valid = 1'b0; d_last = 1'b0; o_ready = 1'b0;
      a_valid = 1'b0; a_data = '0;
      #1;
      test_reset();
      test_single_value();
      test_empty_stall();
      test_full();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
`ifdef DATAFLOW_INVARIANT_Q_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
